// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: control-bundle bit map and the hard-wired zero register.
package cpu_pipe_pkg;

   localparam int CTRL_W = 9;

   localparam int C_REG_WRITE  = 0;
   localparam int C_MEM_READ   = 1;
   localparam int C_MEM_WRITE  = 2;
   localparam int C_MEM_TO_REG = 3;
   localparam int C_ALU_SRC    = 4;
   localparam int C_REG_DST    = 5;
   localparam int C_BRANCH     = 6;
   localparam int C_ALU_OP_LO  = 7;
   localparam int C_ALU_OP_HI  = 8;

   localparam int REG_ZERO = 0;

   typedef logic [CTRL_W-1:0] ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> EX bus: decoded instruction from ID plus flush in, registered EX view plus stall out.
interface id_ex_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   import cpu_pipe_pkg::*;

   logic              id_valid;
   ctrl_t             id_ctrl;
   logic              id_uses_rt;
   logic [DATA_W-1:0] id_rdata1;
   logic [DATA_W-1:0] id_rdata2;
   logic [DATA_W-1:0] id_imm;
   logic [DATA_W-1:0] id_pc_next;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic [REG_AW-1:0] id_rd;
   logic              flush;

   logic              ex_valid;
   ctrl_t             ex_ctrl;
   logic [DATA_W-1:0] ex_rdata1;
   logic [DATA_W-1:0] ex_rdata2;
   logic [DATA_W-1:0] ex_imm;
   logic [DATA_W-1:0] ex_pc_next;
   logic [REG_AW-1:0] ex_rs;
   logic [REG_AW-1:0] ex_rt;
   logic [REG_AW-1:0] ex_rd;
   logic              stall;

   modport master (
      output id_valid, id_ctrl, id_uses_rt, id_rdata1, id_rdata2, id_imm, id_pc_next,
             id_rs, id_rt, id_rd, flush,
      input  ex_valid, ex_ctrl, ex_rdata1, ex_rdata2, ex_imm, ex_pc_next,
             ex_rs, ex_rt, ex_rd, stall
   );

   modport slave (
      input  id_valid, id_ctrl, id_uses_rt, id_rdata1, id_rdata2, id_imm, id_pc_next,
             id_rs, id_rt, id_rd, flush,
      output ex_valid, ex_ctrl, ex_rdata1, ex_rdata2, ex_imm, ex_pc_next,
             ex_rs, ex_rt, ex_rd, stall
   );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard equation: a load in EX whose destination is read by the instruction in ID.
module load_use_detect
   import cpu_pipe_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              ex_valid_i,
   input  logic              ex_mem_read_i,
   input  logic [REG_AW-1:0] ex_rt_i,
   input  logic              id_valid_i,
   input  logic              id_uses_rt_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   output logic              hazard_o
);

   // A load into reg 0 never produces a value anyone waits for.
   assign hazard_o = ex_valid_i & ex_mem_read_i & (ex_rt_i != REG_AW'(REG_ZERO)) & id_valid_i
                   & ((id_rs_i == ex_rt_i) | (id_uses_rt_i & (id_rt_i == ex_rt_i)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures ID each cycle, inserts one bubble on a load-use hazard,
// clears on branch flush and counts inserted bubbles with saturation.
module id_ex_stage
   import cpu_pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   id_ex_stage_if.slave     pipe,
   output logic [CNT_W-1:0] bubble_cnt
);

   typedef struct packed {
      logic              valid;
      ctrl_t             ctrl;
      logic [DATA_W-1:0] rdata1;
      logic [DATA_W-1:0] rdata2;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] pc_next;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
   } ex_t;

   ex_t              ex_d, ex_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             hazard;
   logic             stall;

   load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
      .ex_valid_i    (ex_q.valid),
      .ex_mem_read_i (ex_q.ctrl[C_MEM_READ]),
      .ex_rt_i       (ex_q.rt),
      .id_valid_i    (pipe.id_valid),
      .id_uses_rt_i  (pipe.id_uses_rt),
      .id_rs_i       (pipe.id_rs),
      .id_rt_i       (pipe.id_rt),
      .hazard_o      (hazard)
   );

   assign stall = hazard & ~pipe.flush;

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch; the
      // all-zero default is also exactly the bubble/flush contents.
      ex_d  = '0;
      cnt_d = cnt_q;
      if (stall) begin
         cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      end else if (!pipe.flush) begin
         ex_d.valid   = pipe.id_valid;
         ex_d.ctrl    = pipe.id_valid ? pipe.id_ctrl : '0;
         ex_d.rdata1  = pipe.id_rdata1;
         ex_d.rdata2  = pipe.id_rdata2;
         ex_d.imm     = pipe.id_imm;
         ex_d.pc_next = pipe.id_pc_next;
         ex_d.rs      = pipe.id_rs;
         ex_d.rt      = pipe.id_rt;
         ex_d.rd      = pipe.id_rd;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         ex_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         cnt_q <= cnt_d;
      end
   end

   assign pipe.ex_valid   = ex_q.valid;
   assign pipe.ex_ctrl    = ex_q.ctrl;
   assign pipe.ex_rdata1  = ex_q.rdata1;
   assign pipe.ex_rdata2  = ex_q.rdata2;
   assign pipe.ex_imm     = ex_q.imm;
   assign pipe.ex_pc_next = ex_q.pc_next;
   assign pipe.ex_rs      = ex_q.rs;
   assign pipe.ex_rt      = ex_q.rt;
   assign pipe.ex_rd      = ex_q.rd;
   assign pipe.stall      = stall;
   assign bubble_cnt      = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed ID traffic into a full-width and a 2-bit-counter instance,
// checked each cycle against a behavioural model plus literal spot checks.
module tb_id_ex_stage;
   import cpu_pipe_pkg::*;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Bench-side drive variables, fanned out to both instances.
   logic              id_valid;
   ctrl_t             id_ctrl;
   logic              id_uses_rt;
   logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm, id_pc_next;
   logic [REG_AW-1:0] id_rs, id_rt, id_rd;
   logic              flush;

   id_ex_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();
   id_ex_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus_sat ();

   assign bus.id_valid       = id_valid;
   assign bus.id_ctrl        = id_ctrl;
   assign bus.id_uses_rt     = id_uses_rt;
   assign bus.id_rdata1      = id_rdata1;
   assign bus.id_rdata2      = id_rdata2;
   assign bus.id_imm         = id_imm;
   assign bus.id_pc_next     = id_pc_next;
   assign bus.id_rs          = id_rs;
   assign bus.id_rt          = id_rt;
   assign bus.id_rd          = id_rd;
   assign bus.flush          = flush;
   assign bus_sat.id_valid   = id_valid;
   assign bus_sat.id_ctrl    = id_ctrl;
   assign bus_sat.id_uses_rt = id_uses_rt;
   assign bus_sat.id_rdata1  = id_rdata1;
   assign bus_sat.id_rdata2  = id_rdata2;
   assign bus_sat.id_imm     = id_imm;
   assign bus_sat.id_pc_next = id_pc_next;
   assign bus_sat.id_rs      = id_rs;
   assign bus_sat.id_rt      = id_rt;
   assign bus_sat.id_rd      = id_rd;
   assign bus_sat.flush      = flush;

   logic [15:0] bubble_cnt;
   logic [1:0]  bubble_cnt_sat;

   id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(16)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .pipe       (bus),
      .bubble_cnt (bubble_cnt)
   );

   id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(2)) u_dut_sat (
      .clk        (clk),
      .rst        (rst),
      .pipe       (bus_sat),
      .bubble_cnt (bubble_cnt_sat)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic              valid;
      ctrl_t             ctrl;
      logic [DATA_W-1:0] rdata1, rdata2, imm, pc_next;
      logic [REG_AW-1:0] rs, rt, rd;
   } ex_view_t;

   ex_view_t m_ex;
   int       m_bubbles = 0;
   bit       m_live    = 1'b0;

   function automatic ex_view_t empty_view();
      ex_view_t v;
      v.valid = 1'b0; v.ctrl = '0; v.rdata1 = '0; v.rdata2 = '0;
      v.imm = '0; v.pc_next = '0; v.rs = '0; v.rt = '0; v.rd = '0;
      return v;
   endfunction

   // ID instruction must wait when it reads the register a load in EX is still fetching.
   function automatic bit model_stall();
      bit reads_it;
      if (flush || !id_valid || !m_ex.valid || !m_ex.ctrl[C_MEM_READ] || m_ex.rt == 0)
         return 1'b0;
      reads_it = (id_rs == m_ex.rt) || (id_uses_rt && id_rt == m_ex.rt);
      return reads_it;
   endfunction

   function automatic int sat(input int n, input int max);
      return (n > max) ? max : n;
   endfunction

   always @(posedge clk) begin
      ex_view_t nxt;
      nxt = empty_view();
      if (rst) begin
         m_bubbles = 0;
      end else if (model_stall()) begin
         m_bubbles = m_bubbles + 1;
      end else if (!flush) begin
         nxt.valid = id_valid;  nxt.ctrl = id_valid ? id_ctrl : '0;
         nxt.rdata1 = id_rdata1; nxt.rdata2 = id_rdata2;
         nxt.imm = id_imm; nxt.pc_next = id_pc_next;
         nxt.rs = id_rs; nxt.rt = id_rt; nxt.rd = id_rd;
      end
      m_ex   = nxt;
      m_live = 1'b1;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (m_live) begin
         check("ex_valid",   64'(bus.ex_valid),     64'(m_ex.valid));
         check("ex_ctrl",    64'(bus.ex_ctrl),      64'(m_ex.ctrl));
         check("ex_rdata1",  64'(bus.ex_rdata1),    64'(m_ex.rdata1));
         check("ex_rdata2",  64'(bus.ex_rdata2),    64'(m_ex.rdata2));
         check("ex_imm",     64'(bus.ex_imm),       64'(m_ex.imm));
         check("ex_pc_next", 64'(bus.ex_pc_next),   64'(m_ex.pc_next));
         check("ex_rs",      64'(bus.ex_rs),        64'(m_ex.rs));
         check("ex_rt",      64'(bus.ex_rt),        64'(m_ex.rt));
         check("ex_rd",      64'(bus.ex_rd),        64'(m_ex.rd));
         check("stall",      64'(bus.stall),        64'(model_stall()));
         check("bubble_cnt", 64'(bubble_cnt),       64'(sat(m_bubbles, 65535)));
         check("sat_stall",  64'(bus_sat.stall),    64'(model_stall()));
         check("sat_ex_rt",  64'(bus_sat.ex_rt),    64'(m_ex.rt));
         check("sat_cnt",    64'(bubble_cnt_sat),   64'(sat(m_bubbles, 3)));
      end
   end

   // ---------------- stimulus ----------------
   localparam ctrl_t CTRL_ALU  = ctrl_t'((1 << C_REG_WRITE) | (2 << C_ALU_OP_LO));
   localparam ctrl_t CTRL_ADD  = ctrl_t'((1 << C_REG_WRITE) | (1 << C_REG_DST) | (2 << C_ALU_OP_LO));
   localparam ctrl_t CTRL_LW   = ctrl_t'((1 << C_REG_WRITE) | (1 << C_MEM_READ) |
                                          (1 << C_MEM_TO_REG) | (1 << C_ALU_SRC));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input ctrl_t c, input logic urt,
                        input int rs, input int rt, input int rd, input logic [31:0] d1);
      id_valid   = v;
      id_ctrl    = c;
      id_uses_rt = urt;
      id_rs      = REG_AW'(rs);
      id_rt      = REG_AW'(rt);
      id_rd      = REG_AW'(rd);
      id_rdata1  = d1;
      id_rdata2  = d1 ^ 32'hA5A5_0000;
      id_imm     = d1 + 32'd4;
      id_pc_next = 32'h0040_0000 + d1;
   endtask

   initial begin
      // 1: reset with random ID inputs
      rst = 1'b1;
      flush = 1'b0;
      drive(1'b1, ctrl_t'($urandom), 1'b1, int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), $urandom);
      step();
      step();
      check("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
      check("rst_ex_ctrl",  64'(bus.ex_ctrl),  64'd0);
      check("rst_stall",    64'(bus.stall),    64'd0);
      check("rst_cnt",      64'(bubble_cnt),   64'd0);
      rst = 1'b0;

      // 2: plain ALU instruction, one-cycle latency
      drive(1'b1, CTRL_ALU, 1'b1, 3, 4, 5, 32'h11);
      step();
      check("plain_ex_rs",     64'(bus.ex_rs),     64'd3);
      check("plain_ex_rt",     64'(bus.ex_rt),     64'd4);
      check("plain_ex_rd",     64'(bus.ex_rd),     64'd5);
      check("plain_ex_rdata1", 64'(bus.ex_rdata1), 64'h11);
      check("plain_ex_valid",  64'(bus.ex_valid),  64'd1);
      check("plain_ex_ctrl",   64'(bus.ex_ctrl),   64'h101);

      // 3: lw r8 then add reading r8 -> one bubble
      drive(1'b1, CTRL_LW, 1'b0, 2, 8, 0, 32'h100);
      step();
      drive(1'b1, CTRL_ADD, 1'b1, 8, 9, 10, 32'h222);
      #1;
      check("lu_stall", 64'(bus.stall), 64'd1);
      step();
      check("lu_bubble_ctrl",  64'(bus.ex_ctrl),  64'd0);
      check("lu_bubble_rt",    64'(bus.ex_rt),    64'd0);
      check("lu_bubble_valid", 64'(bus.ex_valid), 64'd0);
      check("lu_cnt",          64'(bubble_cnt),   64'd1);
      check("lu_stall_drop",   64'(bus.stall),    64'd0);
      step();
      check("lu_add_valid", 64'(bus.ex_valid), 64'd1);
      check("lu_add_rs",    64'(bus.ex_rs),    64'd8);
      check("lu_add_rd",    64'(bus.ex_rd),    64'd10);

      // 4a: load into r0 never stalls
      drive(1'b1, CTRL_LW, 1'b0, 1, 0, 0, 32'h30);
      step();
      drive(1'b1, CTRL_ADD, 1'b1, 0, 5, 6, 32'h31);
      #1;
      check("r0_stall", 64'(bus.stall), 64'd0);
      step();

      // 4b: rt match but rt not read
      drive(1'b1, CTRL_LW, 1'b0, 1, 8, 0, 32'h40);
      step();
      drive(1'b1, CTRL_ALU, 1'b0, 1, 8, 0, 32'h41);
      #1;
      check("no_rt_use_stall", 64'(bus.stall), 64'd0);
      step();

      // 5: hazard and flush together: flush wins
      drive(1'b1, CTRL_LW, 1'b0, 2, 8, 0, 32'h50);
      step();
      drive(1'b1, CTRL_ADD, 1'b1, 8, 9, 10, 32'h51);
      flush = 1'b1;
      #1;
      check("flush_stall", 64'(bus.stall), 64'd0);
      step();
      flush = 1'b0;
      check("flush_ex_valid", 64'(bus.ex_valid), 64'd0);
      check("flush_cnt",      64'(bubble_cnt),   64'd1);

      // 6: five more load-use events
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, CTRL_LW, 1'b0, 2, 7 + i, 0, 32'h600 + 32'(i));
         step();
         drive(1'b1, CTRL_ADD, 1'b1, 1, 7 + i, 12, 32'h700 + 32'(i));
         step();
         step();
      end
      check("sat_main_cnt", 64'(bubble_cnt),     64'd6);
      check("sat_small_cnt", 64'(bubble_cnt_sat), 64'd3);

      // Reset in the middle of a stall
      drive(1'b1, CTRL_LW, 1'b0, 2, 8, 0, 32'h80);
      step();
      drive(1'b1, CTRL_ADD, 1'b1, 8, 9, 10, 32'h81);
      #1;
      check("rst_mid_stall_pre", 64'(bus.stall), 64'd1);
      rst = 1'b1;
      step();
      check("rst_mid_stall",    64'(bus.stall),    64'd0);
      check("rst_mid_cnt",      64'(bubble_cnt),   64'd0);
      check("rst_mid_ex_valid", 64'(bus.ex_valid), 64'd0);
      rst = 1'b0;
      drive(1'b0, CTRL_ADD, 1'b1, 4, 4, 4, 32'h90);
      step();
      check("invalid_ctrl", 64'(bus.ex_ctrl), 64'd0);
      step();

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
